// File: rtl/vx_split_join_ctrl.sv
// vx_split_join_ctrl
//   Warp split/join controller that sits in front of the per-warp IPDOM
//   stacks. A SPLIT computes the then/else masks. On divergence it pushes
//   the reconvergence entry (q1) and the else-path entry (q2) onto the
//   warp's stack. A JOIN pops the top entry and redirects the warp to it.
//   The new mask/PC goes back to the scheduler through a one-deep
//   registered valid/ready slot.
//
//   Stack entry layout: {tmask, pc}.
//
//   Optional build macro: VX_SPLIT_JOIN_PERF_EN adds three 32-bit event
//   counters (perf_splits, perf_divergent, perf_joins).
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   req_*                    SPLIT/JOIN request from the branch unit (valid/ready)
//   stk_push/stk_pop         one-hot per-warp stack strobes, only in the accept cycle
//   stk_q1/stk_q2            entries pushed: q1 = reconvergence, q2 = else path
//   stk_d/stk_empty/stk_full per-warp stack top (combinational) and status
//   rsp_*                    registered response to the warp scheduler
//   err_ovf/err_unf          sticky overflow/underflow flags, cleared by reset only
//   perf_*                   event counters (VX_SPLIT_JOIN_PERF_EN only)
//
// FSM
//   state   | meaning
//   IDLE    | response register empty
//   HOLD    | rsp_valid=1, waiting for rsp_ready

module vx_split_join_ctrl #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32,
    localparam int WIDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int ENTW = NUM_THREADS + PC_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_join,
    input  logic [WIDW-1:0]               req_wid,
    input  logic [NUM_THREADS-1:0]        req_tmask,
    input  logic [NUM_THREADS-1:0]        req_taken,
    input  logic [PC_WIDTH-1:0]           req_pc,
    input  logic [PC_WIDTH-1:0]           req_rpc,
    output logic [NUM_WARPS-1:0]          stk_push,
    output logic [NUM_WARPS-1:0]          stk_pop,
    output logic [ENTW-1:0]               stk_q1,
    output logic [ENTW-1:0]               stk_q2,
    input  logic [NUM_WARPS*ENTW-1:0]     stk_d,
    input  logic [NUM_WARPS-1:0]          stk_empty,
    input  logic [NUM_WARPS-1:0]          stk_full,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WIDW-1:0]               rsp_wid,
    output logic [NUM_THREADS-1:0]        rsp_tmask,
    output logic [PC_WIDTH-1:0]           rsp_pc,
    output logic                          rsp_pc_en,
    output logic                          err_ovf,
    output logic                          err_unf
`ifdef VX_SPLIT_JOIN_PERF_EN
    ,
    output logic [31:0]                   perf_splits,
    output logic [31:0]                   perf_divergent,
    output logic [31:0]                   perf_joins
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]                          state;
    logic                                accept;
    logic [NUM_THREADS-1:0]              then_mask;
    logic [NUM_THREADS-1:0]              else_mask;
    logic                                divergent;
    logic                                do_push;
    logic                                do_pop;
    logic                                split_ovf;
    logic                                join_unf;
    logic [NUM_WARPS-1:0]                wid_onehot;
    logic [NUM_WARPS-1:0][ENTW-1:0]      stk_d_arr;
    logic [ENTW-1:0]                     stk_top;

    assign stk_d_arr = stk_d;
    assign stk_top   = stk_d_arr[req_wid];

    // Gating with reset keeps the stacks untouched while reset is held.
    assign req_ready = !reset && ((state == ST_IDLE) || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign then_mask  = req_tmask & req_taken;
    assign else_mask  = req_tmask & ~req_taken;
    assign divergent  = (then_mask != '0) && (else_mask != '0);
    assign wid_onehot = NUM_WARPS'(1) << req_wid;

    assign do_push   = accept && !req_join && divergent && !stk_full[req_wid];
    assign split_ovf = accept && !req_join && divergent &&  stk_full[req_wid];
    assign do_pop    = accept &&  req_join && !stk_empty[req_wid];
    assign join_unf  = accept &&  req_join &&  stk_empty[req_wid];

    assign stk_push = do_push ? wid_onehot : '0;
    assign stk_pop  = do_pop  ? wid_onehot : '0;
    assign stk_q1   = {req_tmask, req_rpc};
    assign stk_q2   = {else_mask, req_pc};

    assign rsp_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rsp_wid   <= '0;
            rsp_tmask <= '0;
            rsp_pc    <= '0;
            rsp_pc_en <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            if (accept) begin
                state   <= ST_HOLD;
                rsp_wid <= req_wid;
                if (do_pop) begin
                    rsp_tmask <= stk_top[ENTW-1 -: NUM_THREADS];
                    rsp_pc    <= stk_top[PC_WIDTH-1:0];
                    rsp_pc_en <= 1'b1;
                end else begin
                    // Uniform SPLIT, overflowed SPLIT and underflowed JOIN
                    // all keep the current mask and do not redirect the PC.
                    rsp_tmask <= do_push ? then_mask : req_tmask;
                    rsp_pc    <= '0;
                    rsp_pc_en <= 1'b0;
                end
            end else if (rsp_ready) begin
                state <= ST_IDLE;
            end
            if (split_ovf) err_ovf <= 1'b1;
            if (join_unf)  err_unf <= 1'b1;
        end
    end

`ifdef VX_SPLIT_JOIN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_splits    <= '0;
            perf_divergent <= '0;
            perf_joins     <= '0;
        end else begin
            if (accept && !req_join) perf_splits    <= perf_splits + 32'd1;
            if (do_push)             perf_divergent <= perf_divergent + 32'd1;
            if (do_pop)              perf_joins     <= perf_joins + 32'd1;
        end
    end
`endif

endmodule
